apb_master_arb: RTL
===================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 The block SHALL have parameters: ADDR_WIDTH, default 16, APB address width; BUS_WIDTH, default 32, APB data width; STRB_WIDTH, default BUS_WIDTH/8, byte-strobe width; TIMEOUT, default 15, maximum ACCESS cycles before forced error.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, in order: clk_i in 1 clock; rst_i in 1 sync active-high reset.
REQ-004 req_valid_i in 2, per-requester request valid; bit r is requester r.
REQ-005 req_write_i in 2, per-requester write (1) / read (0).
REQ-006 req_addr_i in 2*ADDR_WIDTH, req_wdata_i in 2*BUS_WIDTH, req_strb_i in 2*STRB_WIDTH; requester r occupies slice r.
REQ-007 req_ready_o out 2, one-hot one-cycle accept pulse.
REQ-008 rsp_valid_o out 2, one-hot one-cycle completion pulse; rsp_rdata_o out BUS_WIDTH; rsp_err_o out 1.
REQ-009 psel_o, penable_o, pwrite_o out 1; paddr_o out ADDR_WIDTH; pwdata_o out BUS_WIDTH; pstrb_o out STRB_WIDTH: APB requester signals.
REQ-010 prdata_i in BUS_WIDTH; pready_i in 1; pslverr_i in 1: APB completer signals.
REQ-011 busy_o out 1, high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-013 In IDLE with any req_valid_i bit set, the block SHALL grant one requester, pulse its req_ready_o bit, capture its write/addr/wdata/strb into internal registers, and go to SETUP on the next edge.
REQ-014 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; when one is valid, grant it; last_grant updates only on a grant.
REQ-015 In SETUP, the block SHALL drive psel_o=1, penable_o=0 and the captured transfer fields, then go to ACCESS unconditionally.
REQ-016 In ACCESS, the block SHALL drive psel_o=1, penable_o=1 with the fields unchanged, and hold until pready_i=1 or timeout.
REQ-017 On an ACCESS cycle with pready_i=1, the block SHALL go to IDLE and, in that next cycle, pulse rsp_valid_o for the granted requester, with rsp_err_o=pslverr_i and rsp_rdata_o=prdata_i sampled at completion (rdata is 0 for writes).
REQ-018 A wait-cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready_i=0; if it reaches TIMEOUT, the block SHALL go to IDLE with rsp_err_o=1 and rsp_rdata_o=0.
REQ-019 Outside SETUP/ACCESS, psel_o and penable_o SHALL be 0; paddr_o, pwdata_o, pstrb_o and pwrite_o SHALL hold their last values.
REQ-020 The IDLE cycle that carries an rsp_valid_o pulse SHALL also accept a new request (back-to-back): minimum 3 cycles per zero-wait transfer.
REQ-021 Request inputs SHALL be ignored outside IDLE; requesters hold req_valid_i until accepted.
REQ-022 rsp_rdata_o and rsp_err_o SHALL hold their values until the next completion.

Reset
REQ-023 While rst_i=1 at a clock edge: state=IDLE; all outputs 0 (psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o); counter=0; last_grant=1, so requester 0 wins the first contention.
REQ-024 Reset asserted mid-transfer SHALL abort it without any rsp_valid_o pulse.

Verification
REQ-025 Single write: req0 write addr 0x1234, wdata 0xABCDEFF0, strb 0xF, pready_i=1 -> req_ready_o=01 at cycle T; SETUP at T+1; ACCESS at T+2 with penable_o=1; rsp_valid_o=01, rsp_err_o=0 at T+3.
REQ-026 Read with 2 wait states: req1 read 0x0010, pready_i low 2 ACCESS cycles then high with prdata_i=0x5A5A5A5A -> ACCESS lasts 3 cycles; rsp_valid_o=10; rsp_rdata_o=0x5A5A5A5A.
REQ-027 Contention: both valid from reset, each issuing 2 transfers -> grant order 0,1,0,1; each transfer back-to-back with no idle gap.
REQ-028 Slave error: pslverr_i=1 with pready_i=1 -> rsp_err_o=1 for that response; next transfer reports rsp_err_o=0.
REQ-029 Timeout: pready_i held 0 -> after TIMEOUT(15) ACCESS wait cycles, state returns to IDLE, rsp_err_o=1, rsp_rdata_o=0, psel_o=0.
REQ-030 Mid-ACCESS reset: rst_i=1 for one cycle -> all outputs 0 the next cycle, no rsp_valid_o pulse, and requester 0 is granted first afterwards.

Source files
------------

// File: rtl/apb_master_arb.sv
// apb_master_arb
//
// Two-requester APB master. A round-robin arbiter picks one request in
// IDLE, latches its transfer fields, then runs a standard APB
// SETUP -> ACCESS sequence. Completion (or a wait-state timeout) returns
// a one-cycle response pulse to the granted requester.
//
// Handshake semantics (valid/ready):
//   A requester raises req_valid_i[r] with its fields stable and holds them
//   until it sees req_ready_o[r] high in the same cycle; that cycle is the
//   transfer point and the fields are latched on the following edge.
//   req_ready_o is only ever asserted in IDLE, so requests presented in any
//   other state are simply not accepted yet. rsp_valid_o[r] is a one-cycle
//   pulse with no back-pressure; rsp_rdata_o/rsp_err_o stay valid after it.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i[1:0]      per-requester request valid
//   req_write_i[1:0]      per-requester write(1)/read(0)
//   req_addr_i/wdata_i/strb_i  packed per-requester fields, slice r = requester r
//   req_ready_o[1:0]      one-hot accept pulse
//   rsp_valid_o[1:0]      one-hot completion pulse
//   rsp_rdata_o, rsp_err_o  completion data/error, held until next completion
//   psel_o..pstrb_o       APB requester side
//   prdata_i, pready_i, pslverr_i  APB completer side
//   busy_o                high whenever a transfer is in flight
module apb_master_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int STRB_WIDTH = BUS_WIDTH / 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                req_valid_i,
    input  logic [1:0]                req_write_i,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2*BUS_WIDTH-1:0]    req_wdata_i,
    input  logic [2*STRB_WIDTH-1:0]   req_strb_i,
    output logic [1:0]                req_ready_o,
    output logic [1:0]                rsp_valid_o,
    output logic [BUS_WIDTH-1:0]      rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [ADDR_WIDTH-1:0]     paddr_o,
    output logic [BUS_WIDTH-1:0]      pwdata_o,
    output logic [STRB_WIDTH-1:0]     pstrb_o,
    input  logic [BUS_WIDTH-1:0]      prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              grant_idx;
    logic              accept;
    logic              timeout_hit;

    // Round robin: on contention the requester not granted last wins.
    // last_grant resets to 1 so requester 0 wins the first contention.
    always_comb begin
        grant_idx = req_valid_i[1];
        if (req_valid_i == 2'b11) begin
            grant_idx = ~last_grant_q;
        end
    end

    // Accept is suppressed while reset is asserted so no requester sees a
    // ready pulse for a request that reset is about to discard.
    assign accept      = (state_q == IDLE) && (|req_valid_i) && !rst_i;
    // The counter holds the number of wait cycles already spent, so the
    // TIMEOUT-th consecutive wait cycle is the one that forces completion.
    assign timeout_hit = (state_q == ACCESS) && !pready_i &&
                         (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and combinational outputs.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 2'b00;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_o = grant_idx ? 2'b10 : 2'b01;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                psel_o  = 1'b1;
                busy_o  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                busy_o    = 1'b1;
                if (pready_i || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, captured transfer fields, wait counter and response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            pwrite_o     <= 1'b0;
            paddr_o      <= '0;
            pwdata_o     <= '0;
            pstrb_o      <= '0;
            rsp_valid_o  <= 2'b00;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_o <= 2'b00;

            if (accept) begin
                last_grant_q <= grant_idx;
                grant_q      <= grant_idx;
                pwrite_o     <= grant_idx ? req_write_i[1] : req_write_i[0];
                paddr_o      <= grant_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                          : req_addr_i[ADDR_WIDTH-1:0];
                pwdata_o     <= grant_idx ? req_wdata_i[2*BUS_WIDTH-1:BUS_WIDTH]
                                          : req_wdata_i[BUS_WIDTH-1:0];
                pstrb_o      <= grant_idx ? req_strb_i[2*STRB_WIDTH-1:STRB_WIDTH]
                                          : req_strb_i[STRB_WIDTH-1:0];
            end

            if (state_q == SETUP) begin
                wait_cnt_q <= '0;
            end

            if (state_q == ACCESS) begin
                if (pready_i) begin
                    rsp_valid_o <= {grant_q, ~grant_q};
                    rsp_err_o   <= pslverr_i;
                    rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                end else if (timeout_hit) begin
                    rsp_valid_o <= {grant_q, ~grant_q};
                    rsp_err_o   <= 1'b1;
                    rsp_rdata_o <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
